// File: rtl/rram_adc_readout_packer.sv
// rtl/rram_adc_readout_packer.sv - RRAM core SL-mux sequencer, thermometer ADC decoder and oFIFO packer
// Walks the mux phases, decodes every ADC sample, and pushes either raw codes or per-ADC sums.
module rram_adc_readout_packer #(
   parameter int NUM_ADC         = 32,
   parameter int ADC_WIDTH_THERM = 15,
   parameter int ADC_WIDTH       = 4,
   parameter int MUX_PHASES      = 16,
   parameter int ACC_WIDTH       = 16,
   parameter int DATAOUT_WIDTH   = 64,
   parameter int SETTLE_CYCLES   = 2
) (
   input  logic                                 CLK,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 mode,
   input  logic [$clog2(MUX_PHASES):0]          num_phases,
   input  logic [NUM_ADC*ADC_WIDTH_THERM-1:0]   adc_therm,
   output logic [MUX_PHASES-1:0]                sl_mux_sel,
   output logic                                 push_n_oFIFO,
   input  logic                                 full_oFIFO,
   output logic [DATAOUT_WIDTH-1:0]             din_oFIFO,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 bubble_err
);

   localparam int PH_W      = $clog2(MUX_PHASES) + 1;
   localparam int RAW_WORDS = NUM_ADC * ADC_WIDTH / DATAOUT_WIDTH;
   localparam int ACC_WORDS = NUM_ADC * ACC_WIDTH / DATAOUT_WIDTH;
   localparam int IDX_W     = $clog2((RAW_WORDS > ACC_WORDS) ? RAW_WORDS : ACC_WORDS) + 1;
   localparam int CNT_W     = $clog2(SETTLE_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_SAMPLE = 3'd2;
   localparam logic [2:0] S_PACK   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   // With no settle time a phase starts directly at the sample cycle.
   localparam logic [2:0] S_FIRST  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

   logic [2:0]                       state;
   logic                             mode_q;
   logic [PH_W-1:0]                  n_q;
   logic [PH_W-1:0]                  p_q;
   logic [CNT_W-1:0]                 settle_cnt;
   logic [IDX_W-1:0]                 idx;
   logic [NUM_ADC*ADC_WIDTH-1:0]     code_q;
   logic [NUM_ADC*ACC_WIDTH-1:0]     acc_q;

   logic [NUM_ADC*ADC_WIDTH-1:0]     code_now;
   logic                             bubble_now;
   logic [ADC_WIDTH_THERM-1:0]       therm;
   logic [ADC_WIDTH-1:0]             cnt;
   logic [DATAOUT_WIDTH-1:0]         word_now;
   logic [IDX_W-1:0]                 last_idx;
   logic [PH_W-1:0]                  n_eff;
   logic                             last_phase;

   // Popcount tolerates bubbles; a clean code satisfies therm & (therm+1) == 0.
   always_comb begin
      code_now   = '0;
      bubble_now = 1'b0;
      therm      = '0;
      cnt        = '0;
      for (int i = 0; i < NUM_ADC; i++) begin
         therm = adc_therm[i*ADC_WIDTH_THERM +: ADC_WIDTH_THERM];
         cnt   = '0;
         for (int b = 0; b < ADC_WIDTH_THERM; b++) begin
            cnt = cnt + ADC_WIDTH'(therm[b]);
         end
         code_now[i*ADC_WIDTH +: ADC_WIDTH] = cnt;
         if ((therm & (therm + ADC_WIDTH_THERM'(1))) != '0) begin
            bubble_now = 1'b1;
         end
      end
   end

   always_comb begin
      word_now   = mode_q ? acc_q[int'(idx)*DATAOUT_WIDTH +: DATAOUT_WIDTH]
                          : code_q[int'(idx)*DATAOUT_WIDTH +: DATAOUT_WIDTH];
      last_idx   = mode_q ? IDX_W'(ACC_WORDS - 1) : IDX_W'(RAW_WORDS - 1);
      last_phase = (p_q == n_q - PH_W'(1));
      n_eff      = (num_phases == '0 || num_phases > PH_W'(MUX_PHASES)) ? PH_W'(MUX_PHASES) : num_phases;
      sl_mux_sel = '0;
      if (state == S_SETTLE || state == S_SAMPLE || state == S_PACK) begin
         sl_mux_sel = MUX_PHASES'(1) << p_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state        <= S_IDLE;
         mode_q       <= 1'b0;
         n_q          <= '0;
         p_q          <= '0;
         settle_cnt   <= '0;
         idx          <= '0;
         code_q       <= '0;
         acc_q        <= '0;
         push_n_oFIFO <= 1'b1;
         din_oFIFO    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         bubble_err   <= 1'b0;
      end else begin
         push_n_oFIFO <= 1'b1;
         done         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  n_q        <= n_eff;
                  bubble_err <= 1'b0;
                  acc_q      <= '0;
                  p_q        <= '0;
                  settle_cnt <= '0;
                  idx        <= '0;
                  busy       <= 1'b1;
                  state      <= S_FIRST;
               end
            end
            S_SETTLE: begin
               if (settle_cnt == SET_LAST) begin
                  settle_cnt <= '0;
                  state      <= S_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            S_SAMPLE: begin
               code_q <= code_now;
               if (bubble_now) begin
                  bubble_err <= 1'b1;
               end
               if (mode_q) begin
                  for (int i = 0; i < NUM_ADC; i++) begin
                     acc_q[i*ACC_WIDTH +: ACC_WIDTH] <= acc_q[i*ACC_WIDTH +: ACC_WIDTH]
                                                       + ACC_WIDTH'(code_now[i*ADC_WIDTH +: ADC_WIDTH]);
                  end
               end
               state <= S_PACK;
            end
            S_PACK: begin
               if (mode_q && !last_phase) begin
                  p_q   <= p_q + PH_W'(1);
                  state <= S_FIRST;
               end else if (!full_oFIFO) begin
                  push_n_oFIFO <= 1'b0;
                  din_oFIFO    <= word_now;
                  if (idx == last_idx) begin
                     idx <= '0;
                     if (last_phase) begin
                        state <= S_DONE;
                     end else begin
                        p_q   <= p_q + PH_W'(1);
                        state <= S_FIRST;
                     end
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rram_adc_readout_packer.sv
// tb/tb_rram_adc_readout_packer.sv - directed self-checking bench for rram_adc_readout_packer
module tb_rram_adc_readout_packer;

   logic          CLK = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [4:0]    num_phases;
   logic [479:0]  adc_therm;
   logic [15:0]   sl_mux_sel;
   logic          push_n_oFIFO;
   logic          full_oFIFO;
   logic [63:0]   din_oFIFO;
   logic          busy;
   logic          done;
   logic          bubble_err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [63:0] push_q[$];
   logic [15:0] sel_q[$];
   int          cyc_q[$];

   rram_adc_readout_packer dut (
      .CLK          (CLK),
      .reset        (reset),
      .start        (start),
      .mode         (mode),
      .num_phases   (num_phases),
      .adc_therm    (adc_therm),
      .sl_mux_sel   (sl_mux_sel),
      .push_n_oFIFO (push_n_oFIFO),
      .full_oFIFO   (full_oFIFO),
      .din_oFIFO    (din_oFIFO),
      .busy         (busy),
      .done         (done),
      .bubble_err   (bubble_err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (push_n_oFIFO === 1'b0) begin
         push_q.push_back(din_oFIFO);
         sel_q.push_back(sl_mux_sel);
         cyc_q.push_back(cyc);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      push_q.delete();
      sel_q.delete();
      cyc_q.delete();
   endtask

   task automatic set_all_therm(input logic [14:0] v);
      for (int i = 0; i < 32; i++) adc_therm[i*15 +: 15] = v;
   endtask

   task automatic do_start(input logic m, input logic [4:0] n);
      @(negedge CLK);
      mode       = m;
      num_phases = n;
      start      = 1'b1;
      @(negedge CLK);
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge CLK);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; mode = 1'b0; num_phases = '0;
      full_oFIFO = 1'b0; adc_therm = '0;
      repeat (3) @(negedge CLK);
      n_checks++; if (push_n_oFIFO !== 1'b1) $display("FAIL rst_push_n got %b want 1", push_n_oFIFO); else n_pass++;
      n_checks++; if (din_oFIFO !== 64'h0) $display("FAIL rst_din got %h want 0", din_oFIFO); else n_pass++;
      n_checks++; if (sl_mux_sel !== 16'h0) $display("FAIL rst_sel got %h want 0", sl_mux_sel); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
      n_checks++; if (bubble_err !== 1'b0) $display("FAIL rst_bubble got %b want 0", bubble_err); else n_pass++;
      reset = 1'b1;
   endtask

   task automatic test_raw_single();
      set_all_therm(15'h00FF);
      clear_log();
      do_start(1'b0, 5'd1);
      n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy got %b want 1", busy); else n_pass++;
      n_checks++; if (sl_mux_sel !== 16'h0001) $display("FAIL t1_sel got %h want 0001", sl_mux_sel); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         n_checks++; if (push_n_oFIFO !== 1'b1) $display("FAIL t1_early_push cycle %0d got %b want 1", k, push_n_oFIFO); else n_pass++;
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         n_checks++;
         if (push_n_oFIFO !== 1'b0 || din_oFIFO !== 64'h8888_8888_8888_8888)
            $display("FAIL t1_push%0d got push_n=%b din=%h want 0 8888888888888888", k, push_n_oFIFO, din_oFIFO);
         else n_pass++;
      end
      @(negedge CLK);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || push_n_oFIFO !== 1'b1 || sl_mux_sel !== 16'h0)
         $display("FAIL t1_done got done=%b busy=%b push_n=%b sel=%h want 1 0 1 0000", done, busy, push_n_oFIFO, sl_mux_sel);
      else n_pass++;
      n_checks++; if (bubble_err !== 1'b0) $display("FAIL t1_bubble got %b want 0", bubble_err); else n_pass++;
      @(negedge CLK);
      n_checks++; if (done !== 1'b0) $display("FAIL t1_done_pulse got %b want 0", done); else n_pass++;
   endtask

   task automatic test_acc_full();
      logic ok;
      set_all_therm(15'h7FFF);
      clear_log();
      do_start(1'b1, 5'd0);
      wait_done(400, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL t2_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (push_q.size() != 8) $display("FAIL t2_count got %0d want 8", push_q.size()); else n_pass++;
      for (int k = 0; k < push_q.size(); k++) begin
         n_checks++;
         if (push_q[k] !== 64'h00F0_00F0_00F0_00F0) $display("FAIL t2_word%0d got %h want 00f000f000f000f0", k, push_q[k]);
         else n_pass++;
      end
      if (sel_q.size() > 0) begin
         n_checks++; if (sel_q[0] !== 16'h8000) $display("FAIL t2_first_phase got sel=%h want 8000", sel_q[0]); else n_pass++;
      end
      if (cyc_q.size() == 8) begin
         n_checks++; if (cyc_q[7] - cyc_q[0] != 7) $display("FAIL t2_b2b got span %0d want 7", cyc_q[7] - cyc_q[0]); else n_pass++;
      end
   endtask

   task automatic test_bubble();
      logic ok;
      adc_therm = '0;
      adc_therm[14:0] = 15'b000_0000_0101_1111;
      clear_log();
      do_start(1'b0, 5'd1);
      wait_done(100, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL t3_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (push_q.size() != 2) $display("FAIL t3_count got %0d want 2", push_q.size()); else n_pass++;
      if (push_q.size() == 2) begin
         n_checks++; if (push_q[0] !== 64'h6) $display("FAIL t3_word0 got %h want 6", push_q[0]); else n_pass++;
         n_checks++; if (push_q[1] !== 64'h0) $display("FAIL t3_word1 got %h want 0", push_q[1]); else n_pass++;
      end
      n_checks++; if (bubble_err !== 1'b1) $display("FAIL t3_bubble got %b want 1", bubble_err); else n_pass++;
      repeat (5) @(negedge CLK);
      n_checks++; if (bubble_err !== 1'b1) $display("FAIL t3_bubble_sticky got %b want 1", bubble_err); else n_pass++;
   endtask

   task automatic test_stall();
      logic ok;
      logic [63:0] held;
      logic [15:0] t;
      for (int i = 0; i < 32; i++) begin
         t = (16'd1 << ((i < 16) ? i : 31 - i)) - 16'd1;
         adc_therm[i*15 +: 15] = t[14:0];
      end
      full_oFIFO = 1'b0;
      clear_log();
      do_start(1'b0, 5'd2);
      n_checks++; if (bubble_err !== 1'b0) $display("FAIL t4_bubble_clear got %b want 0", bubble_err); else n_pass++;
      repeat (3) @(negedge CLK);
      full_oFIFO = 1'b1;
      held = din_oFIFO;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         n_checks++;
         if (push_n_oFIFO !== 1'b1 || din_oFIFO !== held)
            $display("FAIL t4_stall%0d got push_n=%b din=%h want 1 %h", k, push_n_oFIFO, din_oFIFO, held);
         else n_pass++;
      end
      full_oFIFO = 1'b0;
      wait_done(100, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL t4_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (push_q.size() != 4) $display("FAIL t4_count got %0d want 4", push_q.size()); else n_pass++;
      if (push_q.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (push_q[k] !== ((k % 2 == 0) ? 64'hFEDC_BA98_7654_3210 : 64'h0123_4567_89AB_CDEF))
               $display("FAIL t4_word%0d got %h want %h", k, push_q[k],
                        (k % 2 == 0) ? 64'hFEDC_BA98_7654_3210 : 64'h0123_4567_89AB_CDEF);
            else n_pass++;
         end
         n_checks++; if (sel_q[2] !== 16'h0002) $display("FAIL t4_phase1_sel got %h want 0002", sel_q[2]); else n_pass++;
         n_checks++; if (cyc_q[1] - cyc_q[0] != 1) $display("FAIL t4_b2b got gap %0d want 1", cyc_q[1] - cyc_q[0]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      set_all_therm(15'h0003);
      clear_log();
      do_start(1'b1, 5'd0);
      repeat (15) @(negedge CLK);
      n_checks++;
      if (sl_mux_sel !== 16'h0008 || push_n_oFIFO !== 1'b1)
         $display("FAIL t5_phase3 got sel=%h push_n=%b want 0008 1", sl_mux_sel, push_n_oFIFO);
      else n_pass++;
      reset = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (push_n_oFIFO !== 1'b1 || din_oFIFO !== 64'h0 || sl_mux_sel !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || bubble_err !== 1'b0)
         $display("FAIL t5_rst got push_n=%b din=%h sel=%h busy=%b done=%b bubble=%b want 1 0 0 0 0 0",
                  push_n_oFIFO, din_oFIFO, sl_mux_sel, busy, done, bubble_err);
      else n_pass++;
      repeat (3) @(negedge CLK);
      reset = 1'b1;
      repeat (3) @(negedge CLK);
      n_checks++; if (push_q.size() != 0) $display("FAIL t5_no_push got %0d want 0", push_q.size()); else n_pass++;
      set_all_therm(15'h00FF);
      clear_log();
      do_start(1'b1, 5'd1);
      wait_done(100, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL t5_timeout got done=%b want 1", done); else n_pass++;
      n_checks++; if (push_q.size() != 8) $display("FAIL t5_count got %0d want 8", push_q.size()); else n_pass++;
      for (int k = 0; k < push_q.size(); k++) begin
         n_checks++;
         if (push_q[k] !== 64'h0008_0008_0008_0008) $display("FAIL t5_word%0d got %h want 0008000800080008", k, push_q[k]);
         else n_pass++;
      end
   endtask

   task automatic test_start_ignored();
      logic ok;
      set_all_therm(15'h00FF);
      clear_log();
      do_start(1'b0, 5'd1);
      @(negedge CLK);
      start = 1'b1;
      wait_done(100, ok);
      start = 1'b0;
      n_checks++; if (ok !== 1'b1) $display("FAIL t6_timeout got done=%b want 1", done); else n_pass++;
      repeat (20) @(negedge CLK);
      n_checks++; if (push_q.size() != 2) $display("FAIL t6_count got %0d want 2", push_q.size()); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL t6_idle_busy got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_raw_single();
      test_acc_full();
      test_bubble();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
